// File: rtl/sm_dot_accumulator_if.sv
// Handshake bundle between a sign-magnitude product stream, its job control,
// and the dot-product accumulator.
interface sm_dot_accumulator_if #(
    parameter int W     = 24,
    parameter int LEN_W = 5
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_sm;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sm;
    logic             out_sat;
    logic             busy;

    modport master (
        output start, len, in_valid, in_sm, out_ready,
        input  in_ready, out_valid, out_sm, out_sat, busy
    );

    modport slave (
        input  start, len, in_valid, in_sm, out_ready,
        output in_ready, out_valid, out_sm, out_sat, busy
    );
endinterface

// File: rtl/sm_dot_accumulator.sv
// Sums a programmed number of sign-magnitude Q(FRAC) products in a wide
// two's-complement register and emits one saturated sign-magnitude result per job.
module sm_dot_accumulator #(
    parameter int W       = 24,
    parameter int FRAC    = 14,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    sm_dot_accumulator_if.slave bus
);
    localparam int G     = $clog2(MAX_LEN);
    localparam int ACC_W = W + G;

    if (FRAC >= W || (1 << LEN_W) <= MAX_LEN) begin : g_bad_params
        $error("sm_dot_accumulator: FRAC must be < W and 2^LEN_W must exceed MAX_LEN");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state, state_d;
    logic [ACC_W-1:0]   acc, acc_d;
    logic [LEN_W-1:0]   cnt, cnt_d;
    logic [W-1:0]       res_sm, res_sm_d;
    logic               res_sat, res_sat_d;
    logic               in_ready_q, out_valid_q, busy_q;

    logic [ACC_W-1:0]   term_mag, term, sum;
    logic               sum_neg;
    logic [ACC_W-1:0]   sum_abs;

    // -0 needs no special case: a zero magnitude negates to zero.
    assign term_mag = {{(ACC_W-W+1){1'b0}}, bus.in_sm[W-2:0]};
    assign term     = bus.in_sm[W-1] ? (~term_mag + 1'b1) : term_mag;
    assign sum      = acc + term;
    assign sum_neg  = sum[ACC_W-1];
    assign sum_abs  = sum_neg ? (~sum + 1'b1) : sum;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state;
        acc_d     = acc;
        cnt_d     = cnt;
        res_sm_d  = res_sm;
        res_sat_d = res_sat;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        res_sm_d  = '0;
                        res_sat_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        acc_d   = '0;
                        cnt_d   = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (bus.in_valid && in_ready_q) begin
                    acc_d = sum;
                    cnt_d = cnt - 1'b1;
                    if (cnt == LEN_W'(1)) begin
                        // Anything above the W-1 magnitude bits means saturation.
                        if (sum_abs[ACC_W-1:W-1] != '0) begin
                            res_sm_d  = {sum_neg, {(W-1){1'b1}}};
                            res_sat_d = 1'b1;
                        end else begin
                            res_sm_d  = {sum_neg, sum_abs[W-2:0]};
                            res_sat_d = 1'b0;
                        end
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    // NOTE: all state, including the accumulator, is cleared by reset so a job
    // aborted by rst_n leaves no partial sum behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            res_sm      <= '0;
            res_sat     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_d;
            acc         <= acc_d;
            cnt         <= cnt_d;
            res_sm      <= res_sm_d;
            res_sat     <= res_sat_d;
            in_ready_q  <= (state_d == ACCUM);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sm    = res_sm;
    assign bus.out_sat   = res_sat;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sm_dot_accumulator.sv
// Directed vector table plus randomized jobs checked against an integer
// reference model of the sign-magnitude dot-product accumulator.
module tb_sm_dot_accumulator;
    localparam int W = 24;
    localparam int MAX_LEN = 16;
    localparam int LEN_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sm_dot_accumulator_if #(.W(W), .LEN_W(LEN_W)) bus ();

    sm_dot_accumulator #(.W(W), .FRAC(14), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int              len;
        int              gapmode;   // 0 none, 1 gap=i, 2 random 0..2
        int              hold;
        bit              glitch;
        logic [15:0][W-1:0] t;
        logic [W-1:0]    exp_sm;
        bit              exp_sat;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] job_terms [MAX_LEN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int len, input int gm, input int hold, input bit gl,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic [W-1:0] d,
                                input logic [W-1:0] fill,
                                input logic [W-1:0] exp_sm, input bit exp_sat);
        vec_t v;
        v.len = len; v.gapmode = gm; v.hold = hold; v.glitch = gl;
        for (int i = 0; i < 16; i++) v.t[i] = fill;
        v.t[0] = a; v.t[1] = b; v.t[2] = c; v.t[3] = d;
        v.exp_sm = exp_sm; v.exp_sat = exp_sat;
        return v;
    endfunction

    // Behavioural reference: plain signed arithmetic, then clamp to the SM range.
    function automatic void ref_model(input int len, output logic [W-1:0] sm, output bit sat);
        longint s = 0;
        longint mag;
        int n = (len > MAX_LEN) ? MAX_LEN : len;
        for (int i = 0; i < n; i++) begin
            longint v = longint'(job_terms[i][W-2:0]);
            s += job_terms[i][W-1] ? -v : v;
        end
        mag = (s < 0) ? -s : s;
        sat = (mag > longint'((1 << (W-1)) - 1));
        if (sat) sm = {(s < 0), {(W-1){1'b1}}};
        else     sm = {(s < 0), mag[W-2:0]};
    endfunction

    task automatic run_job(input string name, input int jl, input int gapmode, input int hold,
                           input bit glitch, input logic [W-1:0] exp_sm, input bit exp_sat);
        int n = (jl > MAX_LEN) ? MAX_LEN : jl;
        @(negedge clk);
        check({name, ".idle"}, 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        bus.len   = LEN_W'(jl);
        @(negedge clk);
        bus.start = 1'b0;
        if (n == 0) begin
            check({name, ".len0_valid"}, 32'(bus.out_valid), 32'd1);
            check({name, ".len0_ready"}, 32'(bus.in_ready), 32'd0);
        end else begin
            check({name, ".ready"}, 32'(bus.in_ready), 32'd1);
            for (int i = 0; i < n; i++) begin
                int g = (gapmode == 1) ? i : (gapmode == 2) ? int'($urandom_range(0, 2)) : 0;
                repeat (g) begin
                    bus.in_valid = 1'b0;
                    bus.in_sm    = W'($urandom);
                    @(negedge clk);
                end
                bus.in_valid = 1'b1;
                bus.in_sm    = job_terms[i];
                bus.start    = glitch && (i == 0);
                @(negedge clk);
                bus.start = 1'b0;
            end
            bus.in_valid = 1'b0;
            check({name, ".valid_timing"}, 32'(bus.out_valid), 32'd1);
            check({name, ".ready_drop"}, 32'(bus.in_ready), 32'd0);
        end
        check({name, ".sm"}, 32'(bus.out_sm), 32'(exp_sm));
        check({name, ".sat"}, 32'(bus.out_sat), 32'(exp_sat));
        repeat (hold) begin
            bus.start = glitch;
            @(negedge clk);
            check({name, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({name, ".hold_sm"}, 32'(bus.out_sm), 32'(exp_sm));
        end
        bus.out_ready = 1'b1;
        bus.start     = glitch;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check({name, ".release_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, ".release_busy"}, 32'(bus.busy), 32'd0);
        check({name, ".release_ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t vecs [8];

    initial begin
        logic [W-1:0] e_sm;
        bit           e_sat;

        vecs[0] = mk(3,  0, 0, 0, 24'h008000, 24'h802000, 24'h005000, 24'h0, 24'h0, 24'h00B000, 0);
        vecs[1] = mk(3,  0, 0, 0, 24'h004000, 24'h804000, 24'h800000, 24'h0, 24'h0, 24'h000000, 0);
        vecs[2] = mk(2,  0, 0, 0, 24'h7FFFFF, 24'h000001, 24'h0, 24'h0, 24'h0, 24'h7FFFFF, 1);
        vecs[3] = mk(2,  0, 0, 0, 24'hFFFFFF, 24'h800001, 24'h0, 24'h0, 24'h0, 24'hFFFFFF, 1);
        vecs[4] = mk(16, 0, 0, 0, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1);
        vecs[5] = mk(4,  1, 0, 0, 24'h010000, 24'h820000, 24'h003000, 24'h800100, 24'h0, 24'h80D100, 0);
        vecs[6] = mk(20, 0, 0, 0, 24'h000001, 24'h000001, 24'h000001, 24'h000001, 24'h000001, 24'h000010, 0);
        vecs[7] = mk(2,  0, 5, 1, 24'h000100, 24'h000200, 24'h0, 24'h0, 24'h0, 24'h000300, 0);

        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
        bus.in_sm = '0;   bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst.in_ready",  32'(bus.in_ready),  32'd0);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out_sm",    32'(bus.out_sm),    32'd0);
        check("rst.out_sat",   32'(bus.out_sat),   32'd0);
        check("rst.busy",      32'(bus.busy),      32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < MAX_LEN; i++) job_terms[i] = vecs[k].t[i];
            run_job($sformatf("vec%0d", k), vecs[k].len, vecs[k].gapmode, vecs[k].hold,
                    vecs[k].glitch, vecs[k].exp_sm, vecs[k].exp_sat);
        end

        // len=0 with a stall on the result side
        run_job("len0", 0, 0, 2, 0, 24'h000000, 0);

        // reset in the middle of a job discards the partial sum
        @(negedge clk);
        bus.start = 1'b1; bus.len = LEN_W'(4);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1; bus.in_sm = 24'h012345;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst.in_ready",  32'(bus.in_ready),  32'd0);
        check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst.out_sm",    32'(bus.out_sm),    32'd0);
        check("midrst.out_sat",   32'(bus.out_sat),   32'd0);
        check("midrst.busy",      32'(bus.busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        job_terms[0] = 24'h80C000;
        run_job("after_rst", 1, 0, 0, 0, 24'h80C000, 0);

        // randomized jobs against the reference model
        for (int j = 0; j < 60; j++) begin
            int jl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 31))
                                                 : int'($urandom_range(0, 16));
            for (int i = 0; i < MAX_LEN; i++) begin
                logic [W-2:0] m = ($urandom_range(0, 1) == 1) ? (W-1)'($urandom)
                                                               : (W-1)'($urandom_range(0, 4095));
                job_terms[i] = {1'($urandom), m};
            end
            ref_model(jl, e_sm, e_sat);
            run_job($sformatf("rnd%0d", j), jl, 2, int'($urandom_range(0, 3)),
                    1'($urandom), e_sm, e_sat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
